// File: rtl/ps2_key_sender.sv
// Keypad emulator: maps one ASCII calculator character to its PS/2 Set-2
// make code and plays make / F0 / make out as device-to-host frames.
module ps2_key_sender #(
   parameter int CLK_DIV    = 4,
   parameter int GAP_CYCLES = 8,
   parameter int SEND_BREAK = 1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       char_valid,
   input  logic [7:0] char_in,
   output logic       ready,
   output logic       done,
   output logic       bad_char,
   output logic       ps2_clk,
   output logic       ps2_data
);

   localparam int CW = $clog2(2 * CLK_DIV);
   localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
   localparam logic [CW-1:0] HALF      = CW'(CLK_DIV);
   localparam logic [CW-1:0] CYC_LAST  = CW'(2 * CLK_DIV - 1);
   localparam logic [GW-1:0] GAP_LAST  = GW'(GAP_CYCLES - 1);
   localparam logic [1:0]    BYTE_LAST = (SEND_BREAK != 0) ? 2'd2 : 2'd0;

   typedef enum logic [2:0] {S_IDLE, S_LOAD, S_BIT, S_GAP, S_FINISH} state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] cyc_q, cyc_d;
   logic [3:0]    bit_q, bit_d;
   logic [GW-1:0] gap_q, gap_d;
   logic [1:0]    byte_q, byte_d;
   logic [7:0]    code_q, code_d;
   logic          bad_q, bad_d;
   logic          ps2_clk_q, ps2_clk_d;
   logic          ps2_data_q, ps2_data_d;

   logic [8:0]  map;
   logic        accept;
   logic        line_active;
   logic [7:0]  tx_byte;
   logic [10:0] frame;

   // {mapped, scan code}
   function automatic logic [8:0] map_char(input logic [7:0] c);
      case (c)
         8'h30:   map_char = {1'b1, 8'h70};
         8'h31:   map_char = {1'b1, 8'h69};
         8'h32:   map_char = {1'b1, 8'h72};
         8'h33:   map_char = {1'b1, 8'h7A};
         8'h34:   map_char = {1'b1, 8'h6B};
         8'h35:   map_char = {1'b1, 8'h73};
         8'h36:   map_char = {1'b1, 8'h74};
         8'h37:   map_char = {1'b1, 8'h6C};
         8'h38:   map_char = {1'b1, 8'h75};
         8'h39:   map_char = {1'b1, 8'h7D};
         8'h2B:   map_char = {1'b1, 8'h79};
         8'h2A:   map_char = {1'b1, 8'h7C};
         8'h3E:   map_char = {1'b1, 8'h49};
         8'h3C:   map_char = {1'b1, 8'h41};
         8'h59:   map_char = {1'b1, 8'h5A};
         8'h4E:   map_char = {1'b1, 8'h76};
         default: map_char = 9'h000;
      endcase
   endfunction

   always_comb begin
      state_d = state_q;
      cyc_d   = cyc_q;
      bit_d   = bit_q;
      gap_d   = gap_q;
      byte_d  = byte_q;
      code_d  = code_q;
      bad_d   = 1'b0;
      ready   = (state_q == S_IDLE) || (state_q == S_FINISH);
      done    = (state_q == S_FINISH);
      map     = map_char(char_in);
      accept  = ready && char_valid;

      case (state_q)
         S_IDLE, S_FINISH: begin
            state_d = S_IDLE;
            if (accept) begin
               if (map[8]) begin
                  state_d = S_LOAD;
                  code_d  = map[7:0];
                  cyc_d   = '0;
                  bit_d   = '0;
                  byte_d  = '0;
               end else begin
                  bad_d = 1'b1;
               end
            end
         end
         // LOAD is the first cycle of byte 0's start bit
         S_LOAD, S_BIT: begin
            state_d = S_BIT;
            if (cyc_q == CYC_LAST) begin
               cyc_d = '0;
               if (bit_q == 4'd10) begin
                  state_d = S_GAP;
                  gap_d   = '0;
               end else begin
                  bit_d = bit_q + 4'd1;
               end
            end else begin
               cyc_d = cyc_q + 1'b1;
            end
         end
         S_GAP: begin
            if (gap_q == GAP_LAST) begin
               if (byte_q == BYTE_LAST) begin
                  state_d = S_FINISH;
               end else begin
                  state_d = S_BIT;
                  byte_d  = byte_q + 2'd1;
                  bit_d   = '0;
                  cyc_d   = '0;
               end
            end else begin
               gap_d = gap_q + 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase

      // Line flops are loaded from the next-state view so they line up with it.
      tx_byte     = (byte_d == 2'd1) ? 8'hF0 : code_d;
      frame       = {1'b1, ~^tx_byte, tx_byte, 1'b0};
      line_active = (state_d == S_LOAD) || (state_d == S_BIT);
      ps2_clk_d   = line_active ? (cyc_d < HALF) : 1'b1;
      ps2_data_d  = line_active ? frame[bit_d] : 1'b1;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         cyc_q      <= '0;
         bit_q      <= '0;
         gap_q      <= '0;
         byte_q     <= '0;
         code_q     <= '0;
         bad_q      <= 1'b0;
         ps2_clk_q  <= 1'b1;
         ps2_data_q <= 1'b1;
      end else begin
         state_q    <= state_d;
         cyc_q      <= cyc_d;
         bit_q      <= bit_d;
         gap_q      <= gap_d;
         byte_q     <= byte_d;
         code_q     <= code_d;
         bad_q      <= bad_d;
         ps2_clk_q  <= ps2_clk_d;
         ps2_data_q <= ps2_data_d;
      end
   end

   assign bad_char = bad_q;
   assign ps2_clk  = ps2_clk_q;
   assign ps2_data = ps2_data_q;

endmodule

// File: tb/tb_ps2_key_sender.sv
// Directed bench for ps2_key_sender: character-map table plus hand-written
// busy-ignore, mid-frame reset and back-to-back sequences.
module tb_ps2_key_sender;

   localparam int D = 4;
   localparam int G = 8;
   localparam int P = 22 * D + G;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       cv  [2];
   logic [7:0] ci  [2];
   logic       rdy [2];
   logic       dn  [2];
   logic       bc  [2];
   logic       pc  [2];
   logic       pd  [2];

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic [7:0] ch;
      logic       mapped;
      logic [7:0] code;
   } vec_t;

   vec_t tbl [19];

   always #5 clk = ~clk;

   ps2_key_sender #(.CLK_DIV(D), .GAP_CYCLES(G), .SEND_BREAK(1)) dut (
      .clk(clk), .rst_n(rst_n), .char_valid(cv[1]), .char_in(ci[1]),
      .ready(rdy[1]), .done(dn[1]), .bad_char(bc[1]),
      .ps2_clk(pc[1]), .ps2_data(pd[1])
   );

   ps2_key_sender #(.CLK_DIV(D), .GAP_CYCLES(G), .SEND_BREAK(0)) dut_mk (
      .clk(clk), .rst_n(rst_n), .char_valid(cv[0]), .char_in(ci[0]),
      .ready(rdy[0]), .done(dn[0]), .bad_char(bc[0]),
      .ps2_clk(pc[0]), .ps2_data(pd[0])
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   task automatic idle_chk(input int u, input string nm, input int n);
      int e;
      e = 0;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         if (rdy[u] !== 1'b1 || dn[u] !== 1'b0 || bc[u] !== 1'b0 ||
             pc[u] !== 1'b1 || pd[u] !== 1'b1) e++;
      end
      chk(nm, e, 0);
   endtask

   // Sends ch, checks every cycle of every frame against the expected waveform,
   // decodes bits at ps2_clk falling edges, and ends in the done cycle.
   // poke >= 0 raises char_valid ('2') for one cycle at S+poke.
   task automatic xmit(input int u, input logic [7:0] ch, input logic [7:0] code, input int poke);
      int         nb, nbit, wbad, o;
      logic [7:0] bytes [3];
      logic [10:0] fr, got;
      logic       prev, ec, ed;
      nb = (u == 1) ? 3 : 1;
      bytes[0] = code;
      bytes[1] = 8'hF0;
      bytes[2] = code;
      cv[u] = 1'b1;
      ci[u] = ch;
      @(posedge clk);
      @(negedge clk);
      cv[u] = 1'b0;
      chk("busy_ready", rdy[u], 0);
      for (int b = 0; b < nb; b++) begin
         fr   = {1'b1, ~^bytes[b], bytes[b], 1'b0};
         got  = '0;
         nbit = 0;
         wbad = 0;
         prev = 1'b1;
         for (int r = 0; r < P; r++) begin
            o = b * P + r;
            if (o > 0) @(negedge clk);
            cv[u] = (o == poke);
            if (o == poke) ci[u] = 8'h32;
            if (r < 22 * D) begin
               ec = ((r % (2 * D)) < D);
               ed = fr[r / (2 * D)];
            end else begin
               ec = 1'b1;
               ed = 1'b1;
            end
            if (pc[u] !== ec || pd[u] !== ed || rdy[u] !== 1'b0 ||
                dn[u] !== 1'b0 || bc[u] !== 1'b0) wbad++;
            if (prev && !pc[u] && nbit < 11) begin
               got[nbit] = pd[u];
               nbit++;
            end
            prev = pc[u];
         end
         chk("frame_wave", wbad, 0);
         chk("frame_bits", got, fr);
      end
      @(negedge clk);
      cv[u] = 1'b0;
      chk("done_pulse", dn[u], 1);
      chk("done_ready", rdy[u], 1);
   endtask

   task automatic bad_seq(input int u, input logic [7:0] ch, input int n);
      cv[u] = 1'b1;
      ci[u] = ch;
      @(posedge clk);
      @(negedge clk);
      cv[u] = 1'b0;
      chk("bad_pulse", bc[u], 1);
      chk("bad_ready", rdy[u], 1);
      idle_chk(u, "bad_quiet", n);
   endtask

   initial begin
      cv[0] = 1'b0; cv[1] = 1'b0;
      ci[0] = 8'h00; ci[1] = 8'h00;

      tbl[0]  = '{8'h30, 1'b1, 8'h70};
      tbl[1]  = '{8'h31, 1'b1, 8'h69};
      tbl[2]  = '{8'h32, 1'b1, 8'h72};
      tbl[3]  = '{8'h33, 1'b1, 8'h7A};
      tbl[4]  = '{8'h34, 1'b1, 8'h6B};
      tbl[5]  = '{8'h35, 1'b1, 8'h73};
      tbl[6]  = '{8'h36, 1'b1, 8'h74};
      tbl[7]  = '{8'h37, 1'b1, 8'h6C};
      tbl[8]  = '{8'h38, 1'b1, 8'h75};
      tbl[9]  = '{8'h39, 1'b1, 8'h7D};
      tbl[10] = '{8'h2B, 1'b1, 8'h79};
      tbl[11] = '{8'h2A, 1'b1, 8'h7C};
      tbl[12] = '{8'h3E, 1'b1, 8'h49};
      tbl[13] = '{8'h3C, 1'b1, 8'h41};
      tbl[14] = '{8'h59, 1'b1, 8'h5A};
      tbl[15] = '{8'h4E, 1'b1, 8'h76};
      tbl[16] = '{8'h41, 1'b0, 8'h00};
      tbl[17] = '{8'hB0, 1'b0, 8'h00};
      tbl[18] = '{8'h2F, 1'b0, 8'h00};

      // reset held for 3 edges
      repeat (3) @(negedge clk);
      chk("rst_ready", rdy[1], 1);
      chk("rst_done", dn[1], 0);
      chk("rst_bad", bc[1], 0);
      chk("rst_clk", pc[1], 1);
      chk("rst_data", pd[1], 1);
      rst_n = 1'b1;
      idle_chk(1, "rst_idle", 3);
      idle_chk(0, "rst_idle_mk", 3);

      for (int i = 0; i < 19; i++) begin
         if (tbl[i].mapped) begin
            xmit(1, tbl[i].ch, tbl[i].code, -1);
            idle_chk(1, "post_done", 2);
         end else begin
            bad_seq(1, tbl[i].ch, (i == 16) ? 200 : 20);
         end
      end

      // request while busy is dropped
      xmit(1, 8'h31, 8'h69, 50);
      idle_chk(1, "ignored_req", 20);

      // reset mid frame 0
      cv[1] = 1'b1;
      ci[1] = 8'h2B;
      @(posedge clk);
      @(negedge clk);
      cv[1] = 1'b0;
      repeat (30) @(negedge clk);
      chk("mid_busy", rdy[1], 0);
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      chk("mid_rst_ready", rdy[1], 1);
      chk("mid_rst_lines", {pc[1], pd[1]}, 2'b11);
      chk("mid_rst_done", dn[1], 0);
      @(negedge clk);
      rst_n = 1'b1;
      idle_chk(1, "mid_rst_idle", 5);
      xmit(1, 8'h59, 8'h5A, -1);
      idle_chk(1, "after_rst", 2);

      // make-only variant, back-to-back accept in the done cycle
      xmit(0, 8'h3C, 8'h41, -1);
      xmit(0, 8'h3E, 8'h49, -1);
      idle_chk(0, "mk_idle", 3);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/ps2_key_sender.md
Name: ps2_key_sender

Overview:
- Inverse of the calculator's scan-code-to-ASCII decode: accepts one ASCII calculator character and emits its PS/2 Set-2 scan code as device-to-host PS/2 frames on ps2_clk/ps2_data.
- Emits make code, then 0xF0, then the make code again, modelling a full keypress and release.
- Used as a keypad/keyboard emulator, driving the calculator's PS/2 receive path in system test and on the board.

Parameters:
- CLK_DIV, 4: system clock cycles per PS/2 clock half-period (D). Must be ≥ 2. Board builds use 2500.
- GAP_CYCLES, 8: idle cycles (both lines high) after each byte's stop bit. Must be ≥ 1.
- SEND_BREAK, 1: 1 sends make, F0, make (3 bytes); 0 sends the make code only (1 byte).

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst_n  in  1  synchronous active-low reset.
- char_valid  in  1  request strobe; sampled only when ready=1.
- char_in  in  8  ASCII character to send.
- ready  out  1  high when idle and able to accept a character.
- done  out  1  one-cycle pulse when the last byte's gap completes.
- bad_char  out  1  one-cycle pulse when an accepted character has no mapping.
- ps2_clk  out  1  generated PS/2 clock; idles high.
- ps2_data  out  1  PS/2 data; idles high.

Behaviour:
- Reset (rst_n=0 at a rising edge), taking effect that same edge, including mid-frame:
  - ready=1, done=0, bad_char=0, ps2_clk=1, ps2_data=1.
  - FSM returns to IDLE; all counters are cleared.
- Character map (ASCII → code):
  - '0'→70, '1'→69, '2'→72, '3'→7A, '4'→6B, '5'→73, '6'→74, '7'→6C, '8'→75, '9'→7D
  - '+'→79, '*'→7C, '>'→49, '<'→41, 'Y'→5A, 'N'→76
  - Any other value is unmapped.
- Accept: a rising edge with ready=1 and char_valid=1.
  - Mapped character: ready=0 from the next cycle, and transmission starts at cycle S (accept edge + 1).
  - Unmapped character: bad_char=1 for exactly the next cycle. ready stays 1, nothing is transmitted, and done is not asserted.
- While ready=0, char_valid is ignored. Nothing is queued.
- FSM states: IDLE → LOAD → BIT (11 bits per frame) → GAP → (next byte: BIT | last byte: FINISH) → IDLE.
- Frame format: start=0, data[0..7] LSB first, odd parity (~^byte), stop=1.
  - Examples: 0x70 parity=0; 0xF0 parity=1; 0x69 parity=1.
- Bit timing, for bit k (0..10) of a frame beginning at cycle F:
  - ps2_data holds the bit from cycle F+2kD.
  - ps2_clk is high for cycles [F+2kD, F+2kD+D) and low for [F+2kD+D, F+2(k+1)D).
  - The falling edge is therefore mid-bit, and data changes only while ps2_clk is high.
- After bit 10: ps2_clk=1, ps2_data=1 for GAP_CYCLES cycles.
  - Byte period P = 22·D + GAP_CYCLES.
  - Byte b (0-based) starts at F = S + b·P.
- Completion:
  - At cycle S + N·P (N = 3 or 1 per SEND_BREAK), done=1 for one cycle and ready=1 in the same cycle.
  - A new char_valid can be accepted in that cycle.
- Byte order for SEND_BREAK=1: code, 0xF0, code.
- ps2_clk and ps2_data are registered outputs with no combinational path from the inputs.
- Host inhibit and host-to-device transfers are not supported. Both lines are push-pull outputs; open-drain conversion is done at the pad.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles, then release → ready=1, done=0, bad_char=0, ps2_clk=1, ps2_data=1. Repeat with rst_n asserted while busy.
- D=4, GAP=8, char_in='0' (0x30) → three frames decoded at ps2_clk falling edges: 0x70 (p=0), 0xF0 (p=1), 0x70 (p=0). Start bits at S, S+96, S+192. done at S+288 with ready=1 the same cycle.
- char_in='A' (0x41, unmapped) → bad_char high exactly 1 cycle, ready never drops, ps2_clk/ps2_data stay high for 200 cycles, no done.
- Send '1' (0x69); pulse char_valid with '2' at S+50 → the '2' request is ignored. Frames are 0x69, F0, 0x69 only, and one done pulse.
- Send '+' (0x79); assert rst_n=0 at S+30 (mid frame 0) → lines high and ready=1 on the reset edge. Send 'Y' after release → clean frames 0x5A, F0, 0x5A.
- SEND_BREAK=0, char_in='<' (0x3C) → single frame 0x41 (p=1), done at S+96. Back-to-back '>' accepted in the done cycle → frame 0x49 starts the next cycle.
